// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the async FIFO write-side arbiter.
//   clog2            : ceiling log2, used for index and counter widths
//   arb_state_t      : arbiter FSM encoding (IDLE=0, BURST=1)
//   DEFAULT_DATASIZE : default FIFO word width, also used by the FIFO top
package fifo_wr_arbiter_pkg;

    localparam int DEFAULT_DATASIZE = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Scans req starting at rr_ptr and wrapping modulo NREQ; the first set bit
// wins.
//   req    : request vector
//   rr_ptr : index with highest priority this cycle
//   grant  : one-hot winner (zero when nothing requested)
//   index  : winner index (zero when nothing requested)
//   any    : at least one request present
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]        grant,
    output logic [clog2(NREQ)-1:0] index,
    output logic                   any
);

    localparam int IDW = clog2(NREQ);

    int pos;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Explicit wrap so non-power-of-two NREQ works.
            pos = int'(rr_ptr) + k;
            if (pos > NREQ - 1) pos = pos - NREQ;
            if (!any && req[IDW'(pos)]) begin
                any               = 1'b1;
                grant[IDW'(pos)]  = 1'b1;
                index             = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO: shares the single write port among
// NREQ requesters with round-robin selection and per-burst locking.
//   wclk, wrst : write clock, asynchronous active-high reset
//   req_*      : per-requester beat valid / packed data / end-of-burst
//   req_ready  : beat accepted this cycle (owner only, blocked by wfull)
//   wfull      : FIFO full flag
//   winc/wdata : FIFO write strobe and data
//   grant      : one-hot owner, zero when idle
//   grant_id   : owner index, meaningful while busy
//   busy       : a burst is locked
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DATASIZE = DEFAULT_DATASIZE,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [NREQ-1:0]          grant,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     busy
);

    localparam int IDW  = clog2(NREQ);
    localparam int CNTW = clog2(MAXBURST + 1);

    arb_state_t          state, state_next;
    logic [NREQ-1:0]     grant_next;
    logic [IDW-1:0]      grant_id_next;
    logic [IDW-1:0]      rr_ptr, rr_ptr_next;
    logic [CNTW-1:0]     beat_cnt, beat_cnt_next;

    logic [NREQ-1:0]     pick_grant;
    logic [IDW-1:0]      pick_id;
    logic                pick_any;

    logic                own_valid;
    logic                own_last;
    logic [DATASIZE-1:0] own_data;
    logic                xfer;
    logic                burst_end;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .index  (pick_id),
        .any    (pick_any)
    );

    // Owner's lane of the request bundle.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant;
        grant_id_next = grant_id;
        rr_ptr_next   = rr_ptr;
        beat_cnt_next = beat_cnt;

        busy      = (state == BURST);
        xfer      = busy && own_valid && !wfull;
        burst_end = xfer && (own_last || (beat_cnt == CNTW'(MAXBURST - 1)));
        winc      = xfer;
        wdata     = busy ? own_data : '0;
        // grant is zero outside BURST, so this also covers the busy term.
        req_ready = grant & {NREQ{!wfull}};

        case (state)
            IDLE: begin
                // Arbitration cycle only; the first beat moves next cycle.
                if (pick_any) begin
                    state_next    = BURST;
                    grant_next    = pick_grant;
                    grant_id_next = pick_id;
                    beat_cnt_next = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    beat_cnt_next = beat_cnt + 1'b1;
                    if (burst_end) begin
                        state_next  = IDLE;
                        grant_next  = '0;
                        rr_ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0
                                                                   : grant_id + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            grant_id <= grant_id_next;
            rr_ptr   <= rr_ptr_next;
            beat_cnt <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (DATASIZE=8, NREQ=4, MAXBURST=4).
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .DATASIZE (8),
        .NREQ     (4),
        .MAXBURST (4)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    // No write strobe may ever coincide with a full FIFO.
    always @(negedge wclk) begin
        total++;
        assert (!(winc === 1'b1 && wfull === 1'b1))
        else begin
            bad++;
            $display("FAIL invariant_winc_wfull: winc=%b wfull=%b required no overlap", winc, wfull);
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        wrst      = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        wfull     = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL reset_winc: got %b want 0", winc); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        total++; if (wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h want 00", wdata); end
        wrst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0010;
        req_data[15:8] = 8'hA1;
        req_last  = 4'b0000;
        settle();
        total++; if (busy !== 1'b0 || winc !== 1'b0 || grant !== 4'b0000) begin
            bad++; $display("FAIL single_arb_cycle: busy=%b winc=%b grant=%b want 0 0 0000", busy, winc, grant);
        end
        tick();
        total++; if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            bad++; $display("FAIL single_grant: grant=%b id=%0d want 0010 1", grant, grant_id);
        end
        for (int k = 0; k < 3; k++) begin
            req_data[15:8] = 8'hA1 + 8'(k);
            req_last[1]    = (k == 2);
            settle();
            total++; if (winc !== 1'b1 || wdata !== 8'hA1 + 8'(k) || req_ready !== 4'b0010) begin
                bad++; $display("FAIL single_beat%0d: winc=%b wdata=%h ready=%b want 1 %h 0010",
                                k, winc, wdata, req_ready, 8'hA1 + 8'(k));
            end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        settle();
        total++; if (busy !== 1'b0 || grant !== 4'b0000 || winc !== 1'b0) begin
            bad++; $display("FAIL single_release: busy=%b grant=%b winc=%b want 0 0000 0", busy, grant, winc);
        end
        // rr_ptr must now be 2: with 0,1,3 valid the scan lands on 3.
        req_valid = 4'b1011;
        req_last  = 4'b1111;
        req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        settle();
        tick();
        total++; if (grant !== 4'b1000 || wdata !== 8'hD3 || winc !== 1'b1) begin
            bad++; $display("FAIL single_rr_ptr: grant=%b wdata=%h winc=%b want 1000 d3 1", grant, wdata, winc);
        end
        tick();
        req_valid = '0;
        settle();
    endtask

    task automatic test_fairness();
        // rr_ptr wrapped from 3 to 0 after the previous burst.
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        for (int k = 0; k < 5; k++) begin
            settle();
            total++; if (busy !== 1'b0 || winc !== 1'b0) begin
                bad++; $display("FAIL fair_idle%0d: busy=%b winc=%b want 0 0", k, busy, winc);
            end
            tick();
            total++; if (grant_id !== 2'(k % 4) || grant !== (4'b0001 << (k % 4)) ||
                         winc !== 1'b1 || wdata !== 8'hD0 + 8'(k % 4)) begin
                bad++; $display("FAIL fair_grant%0d: id=%0d grant=%b winc=%b wdata=%h want id %0d",
                                k, grant_id, grant, winc, wdata, k % 4);
            end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        settle();
    endtask

    task automatic test_maxburst();
        // rr_ptr=1; requester 2 wins, requester 3 waits with a 1-beat burst.
        req_valid = 4'b1100;
        req_last  = 4'b1000;
        req_data[23:16] = 8'h21;
        req_data[31:24] = 8'h30;
        settle();
        tick();
        for (int k = 0; k < 4; k++) begin
            req_data[23:16] = 8'h21 + 8'(k);
            settle();
            total++; if (grant_id !== 2'd2 || winc !== 1'b1 || wdata !== 8'h21 + 8'(k)) begin
                bad++; $display("FAIL maxb_beat%0d: id=%0d winc=%b wdata=%h want 2 1 %h",
                                k, grant_id, winc, wdata, 8'h21 + 8'(k));
            end
            tick();
        end
        total++; if (busy !== 1'b0 || winc !== 1'b0) begin
            bad++; $display("FAIL maxb_forced_release: busy=%b winc=%b want 0 0", busy, winc);
        end
        tick();
        total++; if (grant_id !== 2'd3 || winc !== 1'b1 || wdata !== 8'h30) begin
            bad++; $display("FAIL maxb_next_owner: id=%0d winc=%b wdata=%h want 3 1 30", grant_id, winc, wdata);
        end
        tick();
        req_valid = 4'b0100;
        settle();
        tick();
        for (int k = 0; k < 2; k++) begin
            req_data[23:16] = 8'h25 + 8'(k);
            req_last[2]     = (k == 1);
            settle();
            total++; if (grant_id !== 2'd2 || winc !== 1'b1 || wdata !== 8'h25 + 8'(k)) begin
                bad++; $display("FAIL maxb_regrant%0d: id=%0d winc=%b wdata=%h want 2 1 %h",
                                k, grant_id, winc, wdata, 8'h25 + 8'(k));
            end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL maxb_end: busy=%b want 0", busy); end
    endtask

    task automatic test_wfull();
        // rr_ptr=3; requester 0 is the only one valid.
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        req_data[7:0] = 8'hB1;
        settle();
        tick();
        for (int k = 0; k < 2; k++) begin
            req_data[7:0] = 8'hB1 + 8'(k);
            settle();
            total++; if (winc !== 1'b1 || wdata !== 8'hB1 + 8'(k)) begin
                bad++; $display("FAIL wfull_pre%0d: winc=%b wdata=%h want 1 %h", k, winc, wdata, 8'hB1 + 8'(k));
            end
            tick();
        end
        req_data[7:0] = 8'hB3;
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            total++; if (winc !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0001 || busy !== 1'b1) begin
                bad++; $display("FAIL wfull_stall%0d: winc=%b ready=%b grant=%b busy=%b want 0 0000 0001 1",
                                k, winc, req_ready, grant, busy);
            end
            tick();
        end
        wfull = 1'b0;
        settle();
        total++; if (winc !== 1'b1 || wdata !== 8'hB3 || req_ready !== 4'b0001) begin
            bad++; $display("FAIL wfull_resume: winc=%b wdata=%h ready=%b want 1 b3 0001", winc, wdata, req_ready);
        end
        tick();
        req_data[7:0] = 8'hB4;
        req_last[0]   = 1'b1;
        settle();
        total++; if (busy !== 1'b1 || winc !== 1'b1 || wdata !== 8'hB4) begin
            bad++; $display("FAIL wfull_beat4: busy=%b winc=%b wdata=%h want 1 1 b4", busy, winc, wdata);
        end
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wfull_end: busy=%b want 0", busy); end
    endtask

    task automatic test_gap();
        // rr_ptr=1; only requester 0 valid, so it wins.
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        req_data[7:0] = 8'hC1;
        settle();
        tick();
        total++; if (grant !== 4'b0001 || winc !== 1'b1 || wdata !== 8'hC1) begin
            bad++; $display("FAIL gap_first: grant=%b winc=%b wdata=%h want 0001 1 c1", grant, winc, wdata);
        end
        tick();
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_data[15:8] = 8'hE1;
        for (int k = 0; k < 3; k++) begin
            settle();
            total++; if (winc !== 1'b0 || grant !== 4'b0001 || req_ready !== 4'b0001) begin
                bad++; $display("FAIL gap_hold%0d: winc=%b grant=%b ready=%b want 0 0001 0001",
                                k, winc, grant, req_ready);
            end
            tick();
        end
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        req_data[7:0] = 8'hC2;
        settle();
        total++; if (winc !== 1'b1 || wdata !== 8'hC2) begin
            bad++; $display("FAIL gap_resume: winc=%b wdata=%h want 1 c2", winc, wdata);
        end
        tick();
        req_valid = 4'b0010;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_idle: busy=%b want 0", busy); end
        tick();
        total++; if (grant !== 4'b0010 || winc !== 1'b1 || wdata !== 8'hE1) begin
            bad++; $display("FAIL gap_next: grant=%b winc=%b wdata=%h want 0010 1 e1", grant, winc, wdata);
        end
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
    endtask

    task automatic test_reset_mid();
        // rr_ptr=2; requester 2 starts a long burst.
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data[23:16] = 8'h41;
        settle();
        tick();
        tick();
        req_data[23:16] = 8'h42;
        settle();
        total++; if (winc !== 1'b1 || wdata !== 8'h42) begin
            bad++; $display("FAIL rstmid_beat2: winc=%b wdata=%h want 1 42", winc, wdata);
        end
        #1 wrst = 1'b1;
        #1;
        total++; if (grant !== 4'b0000 || busy !== 1'b0 || winc !== 1'b0 ||
                     req_ready !== 4'b0000 || wdata !== 8'h00) begin
            bad++; $display("FAIL rstmid_immediate: grant=%b busy=%b winc=%b ready=%b wdata=%h want all zero",
                            grant, busy, winc, req_ready, wdata);
        end
        tick();
        wrst = 1'b0;
        req_valid = 4'b0101;
        req_last  = 4'b0001;
        req_data[7:0] = 8'h50;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle: busy=%b want 0", busy); end
        tick();
        total++; if (grant !== 4'b0001 || winc !== 1'b1 || wdata !== 8'h50) begin
            bad++; $display("FAIL rstmid_rearb: grant=%b winc=%b wdata=%h want 0001 1 50", grant, winc, wdata);
        end
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_end: busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_maxburst();
        test_wfull();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
